mem_arbiter: RTL and testbench

//  Shares the single-port Memory between the cpu instruction-fetch path and data path.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and data paths,
// one transaction in flight at a time: IDLE -> ACCESS -> RESP.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              own_if_q, own_if_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              fetch_win;

    // Data has priority unless fetch has been starved for MAX_STREAK grants.
    assign fetch_win = if_req && (!d_req || streak_q == STREAK_MAX);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        own_if_d   = own_if_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    if (fetch_win) begin
                        if_gnt   = 1'b1;
                        own_if_d = 1'b1;
                        addr_d   = if_addr;
                        we_d     = 1'b0;
                        streak_d = '0;
                    end else begin
                        d_gnt    = 1'b1;
                        own_if_d = 1'b0;
                        addr_d   = d_addr;
                        wdata_d  = d_wdata;
                        we_d     = d_we;
                        if (!if_req)
                            streak_d = '0;
                        else if (streak_q != STREAK_MAX)
                            streak_d = streak_q + SW'(1);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    if (own_if_q)
                        if_rdata_d = mem_rdata;
                    else
                        d_rdata_d = we_q ? '0 : mem_rdata;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            streak_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            own_if_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            own_if_q   <= own_if_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = (state_q == ACCESS) && !we_q;
    assign mem_write = (state_q == ACCESS) && we_q;
    assign if_rvalid = (state_q == RESP) && own_if_q;
    assign d_rvalid  = (state_q == RESP) && !own_if_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one LATENCY=1 and one LATENCY=3
// instance share the same stimulus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;

    logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid;
    logic        a_mem_read, a_mem_write;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;

    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid;
    logic        b_mem_read, b_mem_write;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .MAX_STREAK(4)) u_lat1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3), .MAX_STREAK(4)) u_lat3 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_if[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int gcount;
        int last_g;
        int cyc;

        rst = 1'b0; if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state, no requests
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_gnt", {a_if_gnt, a_d_gnt, b_if_gnt, b_d_gnt}, 0);
            check("rst_rvalid", {a_if_rvalid, a_d_rvalid, b_if_rvalid, b_d_rvalid}, 0);
            check("rst_strobe", {a_mem_read, a_mem_write, b_mem_read, b_mem_write}, 0);
            check("rst_data", {b_if_rdata, b_d_rdata}, 0);
            check("rst_mem", {b_mem_addr, b_mem_wdata}, 0);
            tick();
        end

        // LATENCY=1 fetch
        if_req = 1; if_addr = 32'h10; mem_rdata = 32'h8C220004;
        @(negedge clk);
        check("t2_if_gnt", a_if_gnt, 1);
        check("t2_d_gnt", a_d_gnt, 0);
        tick();
        if_req = 0;
        @(negedge clk);
        check("t2_mem_read", a_mem_read, 1);
        check("t2_mem_addr", a_mem_addr, 32'h10);
        check("t2_no_rvalid", a_if_rvalid, 0);
        tick();
        @(negedge clk);
        check("t2_if_rvalid", a_if_rvalid, 1);
        check("t2_if_rdata", a_if_rdata, 32'h8C220004);
        check("t2_strobe_off", a_mem_read, 0);
        repeat (5) tick();

        // LATENCY=3 write
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        check("t3_d_gnt", b_d_gnt, 1);
        check("t3_write_c0", b_mem_write, 0);
        tick();
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("t3_mem_write", {b_mem_write, b_mem_read}, 2'b10);
            check("t3_mem_addr", b_mem_addr, 32'h40);
            check("t3_mem_wdata", b_mem_wdata, 32'hDEADBEEF);
            check("t3_no_rvalid", b_d_rvalid, 0);
            tick();
        end
        @(negedge clk);
        check("t3_d_rvalid", b_d_rvalid, 1);
        check("t3_d_rdata", b_d_rdata, 0);
        check("t3_write_off", b_mem_write, 0);
        check("t3_if_rdata_kept", b_if_rdata, 32'h8C220004);
        tick();
        @(negedge clk);
        check("t3_rvalid_pulse", b_d_rvalid, 0);
        repeat (3) tick();

        // Continuous contention, grant order
        if_req = 1; d_req = 1; d_we = 0;
        if_addr = 32'h100; d_addr = 32'h200; mem_rdata = 32'h01020304;
        gcount = 0; last_g = 0;
        for (cyc = 0; cyc < 80 && gcount < 10; cyc++) begin
            @(negedge clk);
            check("t4_excl", b_if_gnt & b_d_gnt, 0);
            if (b_if_gnt || b_d_gnt) begin
                check("t4_order", b_if_gnt, exp_if[gcount]);
                if (gcount > 0)
                    check("t4_gap", cyc - last_g, 5);
                last_g = cyc;
                gcount++;
            end
            if (gcount < 10)
                tick();
        end
        check("t4_grants", gcount, 10);
        tick();
        if_req = 0; d_req = 0;
        repeat (6) tick();

        // Reset during the second ACCESS cycle
        d_req = 1; d_we = 0; d_addr = 32'h80; mem_rdata = 32'hBADBAD00;
        @(negedge clk);
        check("t5_d_gnt", b_d_gnt, 1);
        tick();
        d_req = 0;
        @(negedge clk);
        check("t5_read_c1", b_mem_read, 1);
        tick();
        rst = 0;
        @(negedge clk);
        check("t5_read_c2", b_mem_read, 1);
        tick();
        rst = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_aborted", {b_mem_read, b_mem_write, b_d_rvalid, b_if_rvalid}, 0);
            if (k == 0)
                check("t5_rdata_clr", b_if_rdata, 0);
            tick();
        end
        if_req = 1; if_addr = 32'h20; mem_rdata = 32'h12345678;
        @(negedge clk);
        check("t5_if_gnt", b_if_gnt, 1);
        tick();
        if_req = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_fetch_read", {b_mem_read, b_mem_addr}, {1'b1, 32'h20});
            tick();
        end
        @(negedge clk);
        check("t5_if_rvalid", b_if_rvalid, 1);
        check("t5_if_rdata", b_if_rdata, 32'h12345678);
        repeat (3) tick();

        // Fetch arriving mid-transaction waits for IDLE
        d_req = 1; d_we = 0; d_addr = 32'h84; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("t6_d_gnt", {b_d_gnt, b_if_gnt}, 2'b10);
        tick();
        d_req = 0; if_req = 1; if_addr = 32'h30;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("t6_if_wait", b_if_gnt, 0);
            tick();
        end
        @(negedge clk);
        check("t6_d_rvalid", b_d_rvalid, 1);
        check("t6_d_rdata", b_d_rdata, 32'hCAFEF00D);
        check("t6_if_wait_resp", b_if_gnt, 0);
        tick();
        @(negedge clk);
        check("t6_if_gnt", b_if_gnt, 1);
        tick();
        if_req = 0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
